// File: rtl/axis_dma_dac4_16.sv
// AXI4-Stream byte sink that packs 8-byte frames and plays them to a quad 16-bit SPI DAC.
// Optional macro DAC_LDAC_EN: write input registers, then update all four outputs together with a LDAC strobe.
module axis_dma_dac4_16 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] play_len,
   input  logic        play_start,
   input  logic [15:0] sample_period,
   output logic        busy,
   output logic        done,
   output logic [15:0] underrun_cnt,
   output logic        frame_err,
   input  logic [7:0]  DMA_AXIS_tdata,
   input  logic        DMA_AXIS_tkeep,
   input  logic        DMA_AXIS_tlast,
   input  logic        DMA_AXIS_tvalid,
   output logic        DMA_AXIS_tready,
   output logic        dac_cs_n,
   output logic        dac_sck,
   output logic        dac_sdi,
   output logic        dac_ldac_n
);
   localparam logic [3:0]  DAC_CMD_WRUPD = 4'h3;
   localparam logic [3:0]  DAC_CMD_WR    = 4'h0;
   localparam logic [15:0] MIN_PERIOD    = 16'd208;
`ifdef DAC_LDAC_EN
   localparam logic [3:0]  CH_CMD = DAC_CMD_WR;
`else
   localparam logic [3:0]  CH_CMD = DAC_CMD_WRUPD;
`endif

   typedef enum logic [0:0] {C_IDLE, C_RUN} ctrl_t;
   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP, S_LDAC} spi_t;

   ctrl_t       ctrl_r, ctrl_nxt;
   spi_t        spi_r, spi_nxt;
   logic [31:0] frames_acc_r, frames_acc_nxt, frames_play_r, frames_play_nxt;
   logic [2:0]  byte_cnt_r, byte_cnt_nxt;
   logic [15:0] per_cnt_r, per_cnt_nxt, underrun_r, underrun_nxt, period_s;
   logic        frame_err_r, frame_err_nxt, buf_full_r, buf_full_nxt;
   logic [63:0] buf_r, buf_nxt, out_r, out_nxt;
   logic        tready_r, busy_r, done_r, done_nxt;
   logic        tick_s, spi_start_s, exp_last_s;
   logic [5:0]  cyc_r, cyc_nxt;
   logic [1:0]  ch_r, ch_nxt;
   logic        gap_r, gap_nxt;
   logic [23:0] word_s;
   logic        cs_n_r, cs_n_nxt, sck_r, sck_nxt, sdi_r, sdi_nxt, ldac_n_r, ldac_n_nxt;
   logic        unused_s;

   assign unused_s = DMA_AXIS_tkeep;
   assign period_s = (sample_period < MIN_PERIOD) ? MIN_PERIOD : sample_period;

   // Channel n carries ch(n+1), which sits in the upper bits of the frame.
   function automatic logic [23:0] dac_word(input logic [3:0] cmd, input logic [1:0] ch,
                                            input logic [63:0] frame);
      logic [15:0] d;
      case (ch)
         2'd0:    d = frame[63:48];
         2'd1:    d = frame[47:32];
         2'd2:    d = frame[31:16];
         2'd3:    d = frame[15:0];
         default: d = 16'h0000;
      endcase
      return {cmd, 2'b00, ch, d};
   endfunction

   // Run control, byte assembly, tlast check, sample ticks and underrun accounting.
   always_comb begin
      ctrl_nxt        = ctrl_r;
      frames_acc_nxt  = frames_acc_r;
      frames_play_nxt = frames_play_r;
      byte_cnt_nxt    = byte_cnt_r;
      per_cnt_nxt     = per_cnt_r;
      underrun_nxt    = underrun_r;
      frame_err_nxt   = frame_err_r;
      buf_full_nxt    = buf_full_r;
      buf_nxt         = buf_r;
      out_nxt         = out_r;
      done_nxt        = 1'b0;
      tick_s          = 1'b0;
      spi_start_s     = 1'b0;
      exp_last_s      = 1'b0;
      case (ctrl_r)
         C_IDLE: begin
            if (play_start) begin
               ctrl_nxt        = C_RUN;
               frames_acc_nxt  = 32'd0;
               frames_play_nxt = 32'd0;
               byte_cnt_nxt    = 3'd0;
               per_cnt_nxt     = 16'd0;
               underrun_nxt    = 16'd0;
               frame_err_nxt   = 1'b0;
               buf_full_nxt    = 1'b0;
            end else begin
               ctrl_nxt = C_IDLE;
            end
         end
         C_RUN: begin
            if (DMA_AXIS_tvalid && tready_r) begin
               buf_nxt[{byte_cnt_r, 3'b000} +: 8] = DMA_AXIS_tdata;
               exp_last_s   = (byte_cnt_r == 3'd7) && (frames_acc_r == play_len - 32'd1);
               byte_cnt_nxt = byte_cnt_r + 3'd1;
               if (DMA_AXIS_tlast != exp_last_s) begin
                  frame_err_nxt = 1'b1;
               end else begin
                  frame_err_nxt = frame_err_r;
               end
               if (byte_cnt_r == 3'd7) begin
                  buf_full_nxt   = 1'b1;
                  frames_acc_nxt = frames_acc_r + 32'd1;
               end else begin
                  buf_full_nxt   = buf_full_r;
               end
            end else begin
               byte_cnt_nxt = byte_cnt_r;
            end
            // >= rather than == so a period lowered mid-run cannot skip the wrap.
            tick_s      = (per_cnt_r >= period_s - 16'd1);
            per_cnt_nxt = tick_s ? 16'd0 : per_cnt_r + 16'd1;
            if (tick_s && buf_full_r && (spi_r == S_IDLE)) begin
               out_nxt         = buf_r;
               buf_full_nxt    = 1'b0;
               spi_start_s     = 1'b1;
               frames_play_nxt = frames_play_r + 32'd1;
            end else if (tick_s && (frames_play_r < play_len) && (underrun_r != 16'hFFFF)) begin
               underrun_nxt = underrun_r + 16'd1;
            end else begin
               underrun_nxt = underrun_r;
            end
            if ((frames_play_r == play_len) && (spi_r == S_IDLE)) begin
               ctrl_nxt = C_IDLE;
               done_nxt = 1'b1;
            end else begin
               ctrl_nxt = C_RUN;
            end
         end
         default: ctrl_nxt = C_IDLE;
      endcase
   end

   // Control state and registered status/handshake outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ctrl_r        <= C_IDLE;
         frames_acc_r  <= 32'd0;
         frames_play_r <= 32'd0;
         byte_cnt_r    <= 3'd0;
         per_cnt_r     <= 16'd0;
         underrun_r    <= 16'd0;
         frame_err_r   <= 1'b0;
         buf_full_r    <= 1'b0;
         buf_r         <= 64'd0;
         out_r         <= 64'd0;
         tready_r      <= 1'b0;
         busy_r        <= 1'b0;
         done_r        <= 1'b0;
      end else begin
         ctrl_r        <= ctrl_nxt;
         frames_acc_r  <= frames_acc_nxt;
         frames_play_r <= frames_play_nxt;
         byte_cnt_r    <= byte_cnt_nxt;
         per_cnt_r     <= per_cnt_nxt;
         underrun_r    <= underrun_nxt;
         frame_err_r   <= frame_err_nxt;
         buf_full_r    <= buf_full_nxt;
         buf_r         <= buf_nxt;
         out_r         <= out_nxt;
         tready_r      <= (ctrl_nxt == C_RUN) && !buf_full_nxt && (frames_acc_nxt < play_len);
         busy_r        <= (ctrl_nxt == C_RUN);
         done_r        <= done_nxt;
      end
   end

   // SPI sequencer; pins are decoded from next-state so they leave flops aligned to state.
   always_comb begin
      spi_nxt = spi_r;
      cyc_nxt = cyc_r;
      ch_nxt  = ch_r;
      gap_nxt = gap_r;
      case (spi_r)
         S_IDLE: begin
            if (spi_start_s) begin
               spi_nxt = S_SHIFT;
               cyc_nxt = 6'd0;
               ch_nxt  = 2'd0;
            end else begin
               spi_nxt = S_IDLE;
            end
         end
         S_SHIFT: begin
            if (cyc_r == 6'd47) begin
               spi_nxt = S_GAP;
               gap_nxt = 1'b0;
            end else begin
               cyc_nxt = cyc_r + 6'd1;
            end
         end
         S_GAP: begin
            if (gap_r && (ch_r == 2'd3)) begin
`ifdef DAC_LDAC_EN
               spi_nxt = S_LDAC;
               gap_nxt = 1'b0;
`else
               spi_nxt = S_IDLE;
`endif
            end else if (gap_r) begin
               spi_nxt = S_SHIFT;
               ch_nxt  = ch_r + 2'd1;
               cyc_nxt = 6'd0;
            end else begin
               gap_nxt = 1'b1;
            end
         end
         S_LDAC: begin
            if (gap_r) begin
               spi_nxt = S_IDLE;
            end else begin
               gap_nxt = 1'b1;
            end
         end
         default: spi_nxt = S_IDLE;
      endcase
      word_s     = dac_word(CH_CMD, ch_nxt, out_nxt);
      cs_n_nxt   = (spi_nxt != S_SHIFT);
      sck_nxt    = (spi_nxt == S_SHIFT) && cyc_nxt[0];
      sdi_nxt    = (spi_nxt == S_SHIFT) ? word_s[5'd23 - cyc_nxt[5:1]] : 1'b0;
      ldac_n_nxt = (spi_nxt != S_LDAC);
   end

   // SPI state and DAC pin registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         spi_r    <= S_IDLE;
         cyc_r    <= 6'd0;
         ch_r     <= 2'd0;
         gap_r    <= 1'b0;
         cs_n_r   <= 1'b1;
         sck_r    <= 1'b0;
         sdi_r    <= 1'b0;
         ldac_n_r <= 1'b1;
      end else begin
         spi_r    <= spi_nxt;
         cyc_r    <= cyc_nxt;
         ch_r     <= ch_nxt;
         gap_r    <= gap_nxt;
         cs_n_r   <= cs_n_nxt;
         sck_r    <= sck_nxt;
         sdi_r    <= sdi_nxt;
         ldac_n_r <= ldac_n_nxt;
      end
   end

   assign busy            = busy_r;
   assign done            = done_r;
   assign underrun_cnt    = underrun_r;
   assign frame_err       = frame_err_r;
   assign DMA_AXIS_tready = tready_r;
   assign dac_cs_n        = cs_n_r;
   assign dac_sck         = sck_r;
   assign dac_sdi         = sdi_r;
   assign dac_ldac_n      = ldac_n_r;
endmodule

// File: tb/tb_axis_dma_dac4_16.sv
// Directed bench for axis_dma_dac4_16: an SPI decoder compares every DAC word with a frame-packing model.
module tb_axis_dma_dac4_16;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] play_len = 32'd0;
   logic        play_start = 1'b0;
   logic [15:0] sample_period = 16'd0;
   logic        busy, done, frame_err;
   logic [15:0] underrun_cnt;
   logic [7:0]  DMA_AXIS_tdata = 8'd0;
   logic        DMA_AXIS_tkeep = 1'b1;
   logic        DMA_AXIS_tlast = 1'b0;
   logic        DMA_AXIS_tvalid = 1'b0;
   logic        DMA_AXIS_tready;
   logic        dac_cs_n, dac_sck, dac_sdi, dac_ldac_n;

   axis_dma_dac4_16 dut (
      .clk(clk), .rst_n(rst_n), .play_len(play_len), .play_start(play_start),
      .sample_period(sample_period), .busy(busy), .done(done), .underrun_cnt(underrun_cnt),
      .frame_err(frame_err), .DMA_AXIS_tdata(DMA_AXIS_tdata), .DMA_AXIS_tkeep(DMA_AXIS_tkeep),
      .DMA_AXIS_tlast(DMA_AXIS_tlast), .DMA_AXIS_tvalid(DMA_AXIS_tvalid),
      .DMA_AXIS_tready(DMA_AXIS_tready), .dac_cs_n(dac_cs_n), .dac_sck(dac_sck),
      .dac_sdi(dac_sdi), .dac_ldac_n(dac_ldac_n));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;
   logic [23:0] exp_q[$];
   logic [23:0] word_log[$];
   int          cs_fall_q[$];
   int          done_q[$];
   bit          tready_seen = 1'b0;
   bit          cs_seen = 1'b0;
   int          nbits = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [23:0] get_w(input int i);
      return (word_log.size() > i) ? word_log[i] : 24'h0;
   endfunction

   function automatic int get_f(input int i);
      return (cs_fall_q.size() > i) ? cs_fall_q[i] : -1;
   endfunction

   // Bytes are b[i]=i; frame f packs {ch1,ch2,ch3,ch4} with byte 0 as ch4 low byte.
   task automatic model_frames(input int nframes);
      for (int f = 0; f < nframes; f++) begin
         for (int c = 0; c < 4; c++) begin
            exp_q.push_back({4'h3, 4'(c), 8'(8*f + 7 - 2*c), 8'(8*f + 6 - 2*c)});
         end
      end
   endtask

   task automatic clear_logs();
      exp_q.delete(); word_log.delete(); cs_fall_q.delete(); done_q.delete();
      tready_seen = 1'b0; cs_seen = 1'b0;
   endtask

   // Compare process: decode DAC words on sck rises and check each against the model queue.
   initial begin
      logic prev_cs, prev_sck;
      logic [23:0] sh;
      prev_cs = 1'b1; prev_sck = 1'b0; sh = 24'h0;
      forever begin
         @(negedge clk);
         if (prev_cs && !dac_cs_n) begin
            cs_fall_q.push_back(cyc);
            nbits = 0;
         end
         if (!dac_cs_n && dac_sck && !prev_sck) begin
            sh = {sh[22:0], dac_sdi};
            nbits++;
            if (nbits == 24) begin
               word_log.push_back(sh);
               if (exp_q.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL spi_word_extra actual=%06h expected=none", sh);
               end else begin
                  check("spi_word", sh, exp_q.pop_front());
               end
            end
         end
         if (done) done_q.push_back(cyc);
         if (DMA_AXIS_tready) tready_seen = 1'b1;
         if (!dac_cs_n) cs_seen = 1'b1;
         prev_cs = dac_cs_n;
         prev_sck = dac_sck;
      end
   end

   task automatic start_run(input logic [31:0] len, input logic [15:0] per, output int s);
      @(negedge clk);
      play_len = len; sample_period = per; play_start = 1'b1; s = cyc;
      @(negedge clk);
      play_start = 1'b0;
   endtask

   task automatic send_bytes(input int n, input int last_idx);
      int budget;
      for (int i = 0; i < n; i++) begin
         DMA_AXIS_tdata = 8'(i); DMA_AXIS_tlast = (i == last_idx); DMA_AXIS_tvalid = 1'b1;
         budget = 0;
         while (!DMA_AXIS_tready && budget < 3000) begin
            @(negedge clk); budget++;
         end
         if (budget >= 3000) begin
            checks++; failures++;
            $display("FAIL tready_timeout actual=0 expected=1 byte=%0d", i);
            break;
         end
         @(negedge clk);
      end
      DMA_AXIS_tvalid = 1'b0; DMA_AXIS_tlast = 1'b0;
   endtask

   task automatic wait_done();
      int budget = 0;
      while (!done && budget < 3000) begin
         @(negedge clk); budget++;
      end
      checks++;
      if (!done) begin
         failures++;
         $display("FAIL done_timeout actual=0 expected=1");
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int s, f;
      int budget;
      repeat (3) @(negedge clk);
      check("rst_pins", {busy, done, frame_err, DMA_AXIS_tready, dac_cs_n, dac_sck, dac_sdi, dac_ldac_n},
            8'b0000_1001);
      check("rst_underrun", underrun_cnt, 16'd0);
      rst_n = 1'b1;

      // Nominal two-frame playback.
      clear_logs(); model_frames(2);
      start_run(32'd2, 16'd300, s);
      fork send_bytes(16, 15); join_none
      wait_done();
      check("t1_w0", get_w(0), 24'h300706);
      check("t1_w1", get_w(1), 24'h310504);
      check("t1_w2", get_w(2), 24'h320302);
      check("t1_w3", get_w(3), 24'h330100);
      check("t1_nwords", word_log.size(), 8);
      check("t1_model_drained", exp_q.size(), 0);
      check("t1_first_tick", get_f(0), s + 301);
      check("t1_frame_spacing", get_f(4) - get_f(0), 300);
      check("t1_done_delay", (done_q.size() > 0 ? done_q[0] : -1) - get_f(4), 201);
      check("t1_frame_err", frame_err, 1'b0);
      check("t1_underrun", underrun_cnt, 16'd0);
      check("t1_busy_after", busy, 1'b0);

      // Stream withheld: four empty ticks, then correct playback.
      clear_logs(); model_frames(2);
      start_run(32'd2, 16'd208, s);
      fork begin repeat (1000) @(negedge clk); send_bytes(16, 15); end join_none
      wait_done();
      check("t2_underrun", underrun_cnt, 16'd4);
      check("t2_first_play", get_f(0), s + 1041);
      check("t2_w0", get_w(0), 24'h300706);
      check("t2_model_drained", exp_q.size(), 0);
      check("t2_nwords", word_log.size(), 8);

      // Misplaced tlast: error is sticky but both frames still play.
      clear_logs(); model_frames(2);
      start_run(32'd2, 16'd208, s);
      fork send_bytes(16, 7); join_none
      wait_done();
      check("t3_frame_err", frame_err, 1'b1);
      check("t3_nwords", word_log.size(), 8);
      check("t3_model_drained", exp_q.size(), 0);
      repeat (10) @(negedge clk);
      check("t3_frame_err_sticky", frame_err, 1'b1);

      // Period below the clamp.
      clear_logs(); model_frames(2);
      start_run(32'd2, 16'd10, s);
      check("t4_frame_err_cleared", frame_err, 1'b0);
      fork send_bytes(16, 15); join_none
      wait_done();
      check("t4_first_tick", get_f(0), s + 209);
      check("t4_tick_spacing", get_f(4) - get_f(0), 208);
      check("t4_model_drained", exp_q.size(), 0);

      // Zero-length run.
      clear_logs();
      start_run(32'd0, 16'd300, s);
      wait_done();
      check("t5_done_time", (done_q.size() > 0 ? done_q[0] : -1), s + 2);
      check("t5_done_once", done_q.size(), 1);
      check("t5_no_tready", tready_seen, 1'b0);
      check("t5_no_cs", cs_seen, 1'b0);

      // Reset in the middle of the ch2 word, then a fresh run.
      clear_logs(); model_frames(2);
      start_run(32'd2, 16'd208, s);
      fork send_bytes(16, 15); join_none
      budget = 0;
      while (cs_fall_q.size() < 2 && budget < 3000) begin
         @(negedge clk); budget++;
      end
      check("t6_ch2_started", cs_fall_q.size(), 2);
      f = get_f(1);
      while (cyc < f + 20 && budget < 6000) begin
         @(negedge clk); budget++;
      end
      rst_n = 1'b0;
      @(negedge clk);
      check("t6_rst_cs", dac_cs_n, 1'b1);
      check("t6_rst_tready", DMA_AXIS_tready, 1'b0);
      check("t6_rst_busy", busy, 1'b0);
      check("t6_rst_underrun", underrun_cnt, 16'd0);
      rst_n = 1'b1;
      clear_logs(); model_frames(1);
      start_run(32'd1, 16'd208, s);
      fork send_bytes(8, 7); join_none
      wait_done();
      check("t6_w0", get_w(0), 24'h300706);
      check("t6_w3", get_w(3), 24'h330100);
      check("t6_nwords", word_log.size(), 4);
      check("t6_model_drained", exp_q.size(), 0);
      check("t6_frame_err", frame_err, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/axis_dma_dac4_16.md
# axis_dma_dac4_16

AXI4-Stream slave that accepts 8-bit sample bytes from the DMA MM2S channel, reassembles them into 64-bit four-channel frames ({ch1, ch2, ch3, ch4}, 16 bits each) and plays them out to a quad 16-bit SPI DAC at a programmable sample rate. It is the playback counterpart of the ADC capture path and uses the same 8-byte frame packing, so a buffer captured by the ADC path can be DMA'd straight back out. Control (length, start, period) comes from the PS-side register block; status goes back to it.

## Interface
- DAC_CMD_WRUPD, 4'h3, DAC command "write and update channel n"
- DAC_CMD_WR, 4'h0, DAC command "write input register n"
- MIN_PERIOD, 208, lower clamp for sample_period, in clk cycles

- clk  in  1  single clock for the whole block
- rst_n  in  1  reset, synchronous, active-low
- play_len  in  32  frames to play per run
- play_start  in  1  sampled in IDLE; high starts a run
- sample_period  in  16  clk cycles between sample ticks; values below MIN_PERIOD are treated as MIN_PERIOD
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse at the end of a run
- underrun_cnt  out  16  ticks with no frame ready; saturates at 16'hFFFF
- frame_err  out  1  sticky flag for tlast misplacement
- DMA_AXIS_tdata  in  8  stream byte
- DMA_AXIS_tkeep  in  1  ignored
- DMA_AXIS_tlast  in  1  end of packet
- DMA_AXIS_tvalid  in  1  byte valid
- DMA_AXIS_tready  out  1  byte accepted when tvalid and tready are both high
- dac_cs_n  out  1  DAC chip select
- dac_sck  out  1  DAC serial clock, clk/2 while shifting
- dac_sdi  out  1  DAC serial data, MSB first
- dac_ldac_n  out  1  DAC load strobe

## Operation
- Reset values:
  - Outputs: busy=0, done=0, underrun_cnt=0, frame_err=0, DMA_AXIS_tready=0, dac_cs_n=1, dac_sck=0, dac_sdi=0, dac_ldac_n=1.
  - Internal: all counters 0, buffer empty.
- Control FSM:
  - IDLE → RUN when play_start=1. On entry, clear frames_accepted, frames_played, byte_cnt, period counter, underrun_cnt and frame_err.
  - RUN → IDLE when frames_played==play_len and the SPI engine is idle. Pulse done for one cycle on this transition.
  - play_len=0: RUN lasts one cycle, then done. No bytes are accepted.
- Assembler:
  - tready = RUN && !buf_full && frames_accepted<play_len. It is registered and does not depend on tvalid.
  - Each accepted byte k (byte_cnt 0..7) is written to buf[8k+7:8k], so the first byte is ch4[7:0].
  - When byte_cnt wraps from 7 to 0: set buf_full=1 and increment frames_accepted.
- tlast check:
  - tlast is expected only on byte 7 of frame play_len-1.
  - Set frame_err if tlast=1 on any other accepted byte, or if tlast=0 on that byte. The data is used regardless.
- Period counter:
  - In RUN, counts 0..P-1, where P = max(sample_period, MIN_PERIOD). A tick occurs when it wraps.
  - The first tick is P cycles after RUN entry.
- On each tick:
  - If buf_full and the SPI engine is idle: copy buf to the output register, clear buf_full on the same edge, start SPI, increment frames_played.
  - Otherwise, if frames_played<play_len: increment underrun_cnt (saturating). No SPI transfer, and the DAC holds its previous value.
- SPI engine:
  - States: S_IDLE → S_SHIFT (per channel) → S_GAP → next channel or S_LDAC/S_IDLE.
  - Channel order: ch1 (address 0), ch2 (1), ch3 (2), ch4 (3).
  - Each channel sends a 24-bit word {cmd[3:0], addr[3:0], data[15:0]}, MSB first.

## Timing
- Per channel:
  - dac_cs_n is low for 48 cycles.
  - Bit i occupies cycles 2i and 2i+1: dac_sdi changes with sck low in cycle 2i, and dac_sck=1 in cycle 2i+1. The DAC samples on the rising edge.
  - After the 48 cycles, dac_cs_n is high for 2 cycles (S_GAP).
- One frame takes 200 cycles, or 202 with DAC_LDAC_EN. This is always below MIN_PERIOD, so the engine is idle at every tick unless a previous frame was stalled.
- Tick to first dac_cs_n fall: 1 cycle.
- Byte handshake to buf update: same edge. tready drops on the cycle after byte 7 is accepted.
- Reset asserted mid-run: on that edge everything returns to reset values. dac_cs_n goes high and any partial SPI word is aborted.

## Configuration
- DAC_LDAC_EN defined:
  - Each channel word uses DAC_CMD_WR.
  - After the ch4 S_GAP, S_LDAC drives dac_ldac_n low for 2 cycles, updating all four outputs simultaneously.
- DAC_LDAC_EN undefined:
  - Each channel word uses DAC_CMD_WRUPD.
  - dac_ldac_n is held at 1 and S_LDAC is never entered.

## Test plan
- play_len=2, sample_period=300, 16 bytes 8'h00..8'h0F with tlast on the 16th byte, tvalid always high:
  - First SPI word is 24'h30_0706, then 24'h31_0504, 24'h32_0302, 24'h33_0100.
  - Second frame follows 300 cycles later.
  - done pulses 202 cycles after the second tick.
  - frame_err=0, underrun_cnt=0.
- Same stream with tvalid withheld until 1000 cycles after start, sample_period=208: underrun_cnt=4 before the first SPI transfer, and playback is then correct.
- tlast on byte 8 of a 2-frame run: frame_err=1 stays set until the next play_start; both frames are still played.
- sample_period=10: the tick spacing measured on dac_cs_n falls is 208 cycles.
- play_len=0, play_start=1: done pulses one cycle after RUN entry; tready is never high and dac_cs_n stays 1.
- rst_n low at bit 10 of the ch2 word: on the next edge dac_cs_n=1, tready=0 and busy=0. A new run after reset plays from frame 0.
